// File: rtl/pc_unit_if.sv
// Fetch-side bundle of the program-counter stage: redirect/call/return requests
// in, current fetch PC and return-address-stack status out.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             trap;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             call_valid;
    logic [WIDTH-1:0] call_target;
    logic             ret_valid;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;

    modport master (
        output stall, trap, redirect_valid, redirect_pc, call_valid, call_target, ret_valid,
        input  pc, pc_valid, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, trap, redirect_valid, redirect_pc, call_valid, call_target, ret_valid,
        output pc, pc_valid, ras_empty, ras_full, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage with boot state, prioritised redirects and a circular
// return-address stack used to predict return targets.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int                 INC          = 4,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus_io
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic               pc_valid_q, pc_valid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               underflow_q, underflow_d;
    logic               empty_q, full_q;
    logic               push_en;
    logic [WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [WIDTH-1:0]   pc_inc;
    logic [PTR_W-1:0]   top_idx;

    // The pointer names the next free slot, so the top of stack sits just below it.
    assign pc_inc  = pc_q + WIDTH'(INC);
    assign top_idx = ptr_q - PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_valid_d  = pc_valid_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        push_en     = 1'b0;

        if (state_q == BOOT) begin
            state_d    = RUN;
            pc_valid_d = 1'b1;
            pc_d       = RESET_VECTOR;
        end else if (bus_io.trap) begin
            pc_d = TRAP_VECTOR;
        end else if (bus_io.redirect_valid) begin
            pc_d = bus_io.redirect_pc;
        end else if (bus_io.stall) begin
            pc_d = pc_q;
        end else if (bus_io.ret_valid) begin
            if (count_q != '0) begin
                pc_d    = ras_q[top_idx];
                ptr_d   = top_idx;
                count_d = count_q - CNT_W'(1);
            end else begin
                pc_d        = pc_inc;
                underflow_d = 1'b1;
            end
        end else if (bus_io.call_valid) begin
            // A push into a full stack lands on the oldest slot, so the count saturates.
            pc_d    = bus_io.call_target;
            push_en = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            ptr_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == CNT_W'(RAS_DEPTH));
            if (push_en) begin
                ras_q[ptr_q] <= pc_inc;
            end
        end
    end

    assign bus_io.pc            = pc_q;
    assign bus_io.pc_valid      = pc_valid_q;
    assign bus_io.ras_empty     = empty_q;
    assign bus_io.ras_full      = full_q;
    assign bus_io.ras_underflow = underflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, multi-cycle RAS/wrap/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_pc_unit;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100),
        .INC(4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        trap;
        logic        redir;
        logic [31:0] rpc;
        logic        call;
        logic [31:0] ctgt;
        logic        ret;
        logic [31:0] expPc;
        logic        expEmpty;
        logic        expFull;
        logic        expUf;
    } vec_t;

    vec_t vecs [13];

    // Reference model: the return stack is a plain queue, newest at the back.
    logic        mRunning;
    logic [31:0] mPc;
    logic        mValid;
    logic        mUf;
    logic [31:0] mRas [$];

    task automatic modelStep();
        if (!rst) begin
            mRunning = 1'b0;
            mPc      = 32'h0;
            mValid   = 1'b0;
            mUf      = 1'b0;
            mRas.delete();
        end else if (!mRunning) begin
            mRunning = 1'b1;
            mValid   = 1'b1;
        end else if (bus.trap) begin
            mPc = 32'h100;
        end else if (bus.redirect_valid) begin
            mPc = bus.redirect_pc;
        end else if (bus.stall) begin
            mPc = mPc;
        end else if (bus.ret_valid) begin
            if (mRas.size() > 0) begin
                mPc = mRas.pop_back();
            end else begin
                mPc = mPc + 32'd4;
                mUf = 1'b1;
            end
        end else if (bus.call_valid) begin
            if (mRas.size() == DEPTH) void'(mRas.pop_front());
            mRas.push_back(mPc + 32'd4);
            mPc = bus.call_target;
        end else begin
            mPc = mPc + 32'd4;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic s, input logic t, input logic r, input logic [31:0] rp,
                         input logic c, input logic [31:0] ct, input logic rt);
        bus.stall          = s;
        bus.trap           = t;
        bus.redirect_valid = r;
        bus.redirect_pc    = rp;
        bus.call_valid     = c;
        bus.call_target    = ct;
        bus.ret_valid      = rt;
    endtask

    task automatic applyStimulus(input vec_t v);
        setIn(v.stall, v.trap, v.redir, v.rpc, v.call, v.ctgt, v.ret);
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] ePc, input logic eValid,
                               input logic eEmpty, input logic eFull, input logic eUf);
        checks++;
        if ({bus.pc, bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_underflow} !==
            {ePc, eValid, eEmpty, eFull, eUf}) begin
            errors++;
            $display("[TB] FAIL %s: got pc=%h valid=%b empty=%b full=%b uf=%b, expected pc=%h valid=%b empty=%b full=%b uf=%b",
                     tag, bus.pc, bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_underflow,
                     ePc, eValid, eEmpty, eFull, eUf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        setIn(0, 0, 0, 32'h0, 0, 32'h0, 0);

        //            stall trap redir rpc           call ctgt          ret expPc         E     F     U
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h4,      1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h8,      1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h8,      1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h8,      1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,       1'b0, 32'h40,     1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,       1'b0, 32'h100,    1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 32'h0,       1'b0, 32'h10,     1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h200,     1'b0, 32'h200,    1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h204,    1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'h204,    1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h208,    1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'h14,     1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h50,       1'b1, 32'h900,     1'b0, 32'h50,     1'b1, 1'b0, 1'b0};

        repeat (3) tick();
        checkOutput("reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("boot", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].expPc, 1'b1, vecs[i].expEmpty,
                        vecs[i].expFull, vecs[i].expUf);
        end

        // Five nested calls into a four-entry stack, then unwind past the bottom.
        setIn(0, 0, 1, 32'h1000, 0, 32'h0, 0);
        tick();
        checkOutput("ovf_start", 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            setIn(0, 0, 0, 32'h0, 1, 32'h1000 * (k + 2), 0);
            tick();
            checkOutput($sformatf("ovf_call%0d", k), 32'h1000 * (k + 2), 1'b1, 1'b0,
                        (k >= 3), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            setIn(0, 0, 0, 32'h0, 0, 32'h0, 1);
            tick();
            checkOutput($sformatf("ovf_ret%0d", k), 32'h1000 * (5 - k) + 32'h4, 1'b1,
                        (k == 3), 1'b0, 1'b0);
        end
        tick();
        checkOutput("ovf_ret_underflow", 32'h2008, 1'b1, 1'b1, 1'b0, 1'b1);

        // Simultaneous call and return: the return wins and the call is dropped.
        setIn(0, 0, 0, 32'h0, 1, 32'h9000, 1);
        tick();
        checkOutput("callret_empty", 32'h200C, 1'b1, 1'b1, 1'b0, 1'b1);
        setIn(0, 0, 0, 32'h0, 1, 32'h7000, 0);
        tick();
        checkOutput("callret_push", 32'h7000, 1'b1, 1'b0, 1'b0, 1'b1);
        setIn(0, 0, 0, 32'h0, 1, 32'h9000, 1);
        tick();
        checkOutput("callret_pop", 32'h2010, 1'b1, 1'b1, 1'b0, 1'b1);

        setIn(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        tick();
        checkOutput("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1);
        setIn(0, 0, 0, 32'h0, 0, 32'h0, 0);
        tick();
        checkOutput("wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        setIn(0, 0, 0, 32'h0, 1, 32'h300, 0);
        tick();
        setIn(0, 0, 0, 32'h0, 1, 32'h400, 0);
        tick();
        checkOutput("pre_reset", 32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        setIn(0, 1, 1, 32'h80, 1, 32'h500, 0);
        tick();
        checkOutput("midop_reset", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checkOutput("boot_ignores_inputs", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(99) != 0);
            setIn($urandom_range(99) < 15, $urandom_range(99) < 3, $urandom_range(99) < 8,
                  $urandom() & 32'hFFFF_FFFC, $urandom_range(99) < 20,
                  $urandom() & 32'hFFFF_FFFC, $urandom_range(99) < 20);
            tick();
            checkOutput($sformatf("rand%0d", n), mPc, mValid, (mRas.size() == 0),
                        (mRas.size() == DEPTH), mUf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
